// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: STAGES-deep chunked ripple adder with valid/ready flow control; PIPE_ADD_SUB_EN adds a sub port.
module pipelined_carry_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L = STAGES - 1;
  logic             v_r[STAGES], c_r[STAGES];
  logic [WIDTH-1:0] a_r[STAGES], b_r[STAGES], s_r[STAGES];
  logic             ovf_r;
  logic             v_i[STAGES], c_i[STAGES], c_n[STAGES];
  logic [WIDTH-1:0] a_i[STAGES], b_i[STAGES], s_i[STAGES], s_n[STAGES];
  logic [WIDTH-1:0] b0;
  logic             c0, stall, ovf_n;
`ifdef PIPE_ADD_SUB_EN
  assign b0 = sub ? ~b : b;
  assign c0 = sub | cin;
`else
  assign b0 = b;
  assign c0 = cin;
`endif
  assign stall     = v_r[L] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_r[L];
  assign sum       = s_r[L];
  assign cout      = c_r[L];
  assign ovf       = ovf_r;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0] t;
    if (k == 0) begin : g_first
      assign v_i[k] = in_valid;
      assign c_i[k] = c0;
      assign a_i[k] = a;
      assign b_i[k] = b0;
      assign s_i[k] = '0;
    end else begin : g_next
      assign v_i[k] = v_r[k-1];
      assign c_i[k] = c_r[k-1];
      assign a_i[k] = a_r[k-1];
      assign b_i[k] = b_r[k-1];
      assign s_i[k] = s_r[k-1];
    end
    assign t      = {1'b0, a_i[k][k*CHUNK +: CHUNK]} + {1'b0, b_i[k][k*CHUNK +: CHUNK]} + (CHUNK+1)'(c_i[k]);
    // chunk k of s_i is still zero, so OR-ing the new chunk in is enough
    assign s_n[k] = s_i[k] | (WIDTH'(t[CHUNK-1:0]) << (k*CHUNK));
    assign c_n[k] = t[CHUNK];
  end
  assign ovf_n = (a_i[L][WIDTH-1] == b_i[L][WIDTH-1]) & (s_n[L][WIDTH-1] != a_i[L][WIDTH-1]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
      ovf_r <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= v_i[k];
        c_r[k] <= c_n[k];
        a_r[k] <= a_i[k];
        b_r[k] <= b_i[k];
        s_r[k] <= s_n[k];
      end
      ovf_r <= ovf_n;
    end
  end
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: random and directed stimulus scored against a plain-arithmetic adder model.
module tb_pipelined_carry_adder;
  localparam int W = 32;
  localparam int C = 8;
  localparam int S = W / C;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [W-1:0] s; logic co; logic ov;} res_t;
  res_t q[$];
  logic stalled_prev = 1'b0;
  logic [W-1:0] sum_prev;
  always #5 clk = ~clk;
  pipelined_carry_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    logic [W:0] f;
    logic [W-1:0] yy;
    res_t r;
    yy = sb ? ~y : y;
    f = {1'b0, x} + {1'b0, yy} + (W+1)'(sb ? 1'b1 : ci);
    r.s = f[W-1:0];
    r.co = f[W];
    r.ov = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
    return r;
  endfunction
  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (stalled_prev && out_valid) check("stall_sum", sum, sum_prev);
      if (out_valid && out_ready) begin
        check("q_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.co);
          check("ovf", ovf, e.ov);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      stalled_prev = out_valid && !out_ready;
      sum_prev = sum;
    end else stalled_prev = 1'b0;
  end
  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    in_valid = v;
    a = x;
    b = y;
    cin = ci;
    sub = sb;
  endtask
  task automatic drive_rand(input logic v);
`ifdef PIPE_ADD_SUB_EN
    drive(v, $urandom, $urandom, 1'($urandom), 1'($urandom));
`else
    drive(v, $urandom, $urandom, 1'($urandom), 1'b0);
`endif
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb,
                          input logic [W-1:0] es, input logic eco, input logic eov);
    int n;
    drive(1'b1, x, y, ci, sb);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, S);
    check("dir_sum", sum, es);
    check("dir_cout", cout, eco);
    check("dir_ovf", ovf, eov);
    tick();
  endtask
  initial begin
    logic [W-1:0] held;
    int n;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("in_ready_after_rst", in_ready, 1);
    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1);
`ifdef PIPE_ADD_SUB_EN
    directed(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed(32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`endif
    repeat (S) tick();
    for (int i = 1; i <= 16; i++) begin
      drive_rand(1'b1);
      tick();
      check("stream_valid", out_valid, i >= S);
    end
    in_valid = 1'b0;
    for (int i = 17; i <= 16 + S + 1; i++) begin
      tick();
      check("stream_tail_valid", out_valid, i <= 16 + S - 1);
    end
    for (int i = 0; i < S + 2; i++) begin
      drive_rand(1'b1);
      tick();
    end
    check("bp_full", out_valid, 1);
    held = sum;
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
      check("bp_in_ready_hold", in_ready, 0);
      check("bp_sum_hold", sum, held);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (S + 1) tick();
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    q.delete();
    tick();
    rst = 1'b0;
    check("in_ready_post_rst", in_ready, 1);
    for (int i = 0; i < 2 * S; i++) begin
      tick();
      check("no_stale_result", out_valid, 0);
    end
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
